// File: rtl/timer_6502.sv
// 16-bit programmable interval timer slave for the 6502 SoC bus (page 3).
// Optional prescaler enabled by defining TIMER_PRESCALE_EN.
module timer_6502 #(
  parameter logic [15:0] RELOAD_RST = 16'hFFFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       we,
  input  logic [1:0] rs,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       irq
);

  logic [15:0] cnt, reload;
  logic [7:0]  hi_latch, rdata;
  logic        en, ie, cont, if_flag;
  logic [1:0]  ps;
  logic        tick, underflow;
  logic        bus_wr, bus_rd, wr_lo, wr_hi, wr_ctrl, wr_stat;

  assign bus_wr  = cs & we;
  assign bus_rd  = cs & ~we;
  assign wr_lo   = bus_wr & (rs == 2'd0);
  assign wr_hi   = bus_wr & (rs == 2'd1);
  assign wr_ctrl = bus_wr & (rs == 2'd2);
  assign wr_stat = bus_wr & (rs == 2'd3);

`ifdef TIMER_PRESCALE_EN
  logic [7:0] prescaler, mask;

  always_comb begin
    mask = 8'h00;
    case (ps)
      2'd0: mask = 8'h00;
      2'd1: mask = 8'h07;
      2'd2: mask = 8'h3F;
      2'd3: mask = 8'hFF;
      default: mask = 8'h00;
    endcase
  end

  assign tick = (prescaler & mask) == mask;

  // Restarting the prescaler on any CTRL write makes the first period deterministic.
  always_ff @(posedge clk) begin
    if (reset)        prescaler <= 8'h00;
    else if (wr_ctrl) prescaler <= 8'h00;
    else              prescaler <= prescaler + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset)        ps <= 2'd0;
    else if (wr_ctrl) ps <= din[5:4];
  end
`else
  assign tick = 1'b1;
  assign ps   = 2'd0;
`endif

  assign underflow = en & tick & (cnt == 16'd0);

  // A HI write reloads the counter and beats any same-cycle tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= RELOAD_RST;
      reload <= RELOAD_RST;
    end else begin
      if (wr_lo) reload[7:0] <= din;
      if (wr_hi) begin
        reload[15:8] <= din;
        cnt          <= {din, reload[7:0]};
      end else if (en && tick) begin
        if (cnt != 16'd0) cnt <= cnt - 16'd1;
        else if (cont)    cnt <= reload;
      end
    end
  end

  // IF priority: load clear > underflow set > status clear.
  always_ff @(posedge clk) begin
    if (reset)                 if_flag <= 1'b0;
    else if (wr_hi)            if_flag <= 1'b0;
    else if (underflow)        if_flag <= 1'b1;
    else if (wr_stat && din[7]) if_flag <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en   <= 1'b0;
      ie   <= 1'b0;
      cont <= 1'b0;
    end else if (wr_ctrl) begin
      en   <= din[0];
      ie   <= din[1];
      cont <= din[2];
    end else if (underflow && !cont) begin
      en <= 1'b0;
    end
  end

  always_comb begin
    rdata = 8'h00;
    case (rs)
      2'd0: rdata = cnt[7:0];
      2'd1: rdata = hi_latch;
      2'd2: rdata = {2'b00, ps, 1'b0, cont, ie, en};
      2'd3: rdata = {if_flag, 6'b0, en};
      default: rdata = 8'h00;
    endcase
  end

  // LO read snapshots the high byte so a following HI read is tear-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout     <= 8'h00;
      hi_latch <= 8'h00;
    end else if (bus_rd) begin
      dout <= rdata;
      if (rs == 2'd0) hi_latch <= cnt[15:8];
    end
  end

  assign irq = if_flag & ie;

endmodule

// File: tb/tb_timer_6502.sv
// Self-checking bench for timer_6502: read results go through an expected-value queue.
module tb_timer_6502;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cs = 1'b0, we = 1'b0;
  logic [1:0] rs = 2'd0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       irq;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  string      nm_q[$];

  timer_6502 #(.RELOAD_RST(16'hFFFF)) dut (
    .clk(clk), .reset(reset), .cs(cs), .we(we), .rs(rs),
    .din(din), .dout(dout), .irq(irq)
  );

  always #5 clk = ~clk;

  // Scoreboard consumer: every read edge pops one expected byte.
  always begin
    logic [7:0] e;
    string n;
    @(posedge clk);
    if (cs && !we && !reset) begin
      #1;
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      checks++;
      if (dout !== e) begin
        errors++;
        $display("FAIL %s: dout=%h expected %h", n, dout, e);
      end
    end
  end

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; rs = a; din = d;
    @(posedge clk); #1;
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] e, input string n);
    cs = 1'b1; we = 1'b0; rs = a;
    exp_q.push_back(e);
    nm_q.push_back(n);
    @(posedge clk); #1;
    cs = 1'b0;
  endtask

  task automatic cycles(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Returns edges until irq rises; bound+1 when it never does.
  task automatic wait_irq(input int bound, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!irq && n <= bound);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    cycles(3);
    reset = 1'b0;
    checks++;
    if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: dout=%h expected 00", dout); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: irq=%b expected 0", irq); end
    rd(2'd2, 8'h00, "reset_ctrl");
    rd(2'd0, 8'hFF, "reset_cnt_lo");
    rd(2'd1, 8'hFF, "reset_cnt_hi");
  endtask

  task automatic test_continuous;
    int n;
    wr(2'd0, 8'h04);
    wr(2'd1, 8'h00);
    wr(2'd2, 8'h07);
    wait_irq(20, n);
    checks++;
    if (n !== 5) begin errors++; $display("FAIL cont_period: edges=%0d expected 5", n); end
    rd(2'd0, 8'h04, "cont_reload");
    wr(2'd3, 8'h80);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL cont_clear: irq=%b expected 0", irq); end
    wait_irq(20, n);
    checks++;
    if (n !== 3) begin errors++; $display("FAIL cont_next: edges=%0d expected 3", n); end
    wr(2'd2, 8'h00);
    wr(2'd3, 8'h80);
  endtask

  task automatic test_oneshot;
    int n;
    wr(2'd0, 8'h02);
    wr(2'd1, 8'h00);
    wr(2'd2, 8'h03);
    wait_irq(20, n);
    checks++;
    if (n !== 3) begin errors++; $display("FAIL oneshot_period: edges=%0d expected 3", n); end
    rd(2'd3, 8'h80, "oneshot_status");
    rd(2'd0, 8'h00, "oneshot_cnt");
    wr(2'd3, 8'h80);
    cycles(10);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_rearm: irq=%b expected 0", irq); end
    rd(2'd3, 8'h00, "oneshot_status_clr");
  endtask

  task automatic test_tear_free;
    wr(2'd0, 8'h00);
    wr(2'd1, 8'h01);
    wr(2'd2, 8'h01);
    rd(2'd0, 8'h00, "tear_lo");
    rd(2'd1, 8'h01, "tear_hi");
    wr(2'd2, 8'h00);
    rd(2'd0, 8'hFD, "tear_lo_frozen");
    rd(2'd1, 8'h00, "tear_hi_frozen");
  endtask

  task automatic test_collisions;
    wr(2'd0, 8'h03);
    wr(2'd1, 8'h00);
    wr(2'd2, 8'h07);
    cycles(3);
    wr(2'd3, 8'h80);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL coll_status: irq=%b expected 1", irq); end
    cycles(3);
    wr(2'd1, 8'h12);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL coll_load: irq=%b expected 0", irq); end
    wr(2'd2, 8'h00);
    rd(2'd0, 8'h02, "coll_cnt_lo");
    rd(2'd1, 8'h12, "coll_cnt_hi");
  endtask

  task automatic test_prescale;
`ifdef TIMER_PRESCALE_EN
    int n;
    wr(2'd0, 8'h01);
    wr(2'd1, 8'h00);
    wr(2'd2, 8'h17);
    wait_irq(40, n);
    checks++;
    if (n !== 16) begin errors++; $display("FAIL ps_first: edges=%0d expected 16", n); end
    wr(2'd3, 8'h80);
    wait_irq(40, n);
    checks++;
    if (n !== 15) begin errors++; $display("FAIL ps_next: edges=%0d expected 15", n); end
    rd(2'd2, 8'h17, "ps_ctrl");
`else
    wr(2'd2, 8'h3F);
    rd(2'd2, 8'h07, "ps_ctrl_masked");
`endif
    wr(2'd2, 8'h00);
    wr(2'd3, 8'h80);
  endtask

  task automatic test_reset_override;
    wr(2'd0, 8'h02);
    wr(2'd1, 8'h00);
    wr(2'd2, 8'h07);
    cycles(2);
    cs = 1'b1; we = 1'b1; rs = 2'd1; din = 8'h55; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; cs = 1'b0; we = 1'b0;
    checks++;
    if (dout !== 8'h00) begin errors++; $display("FAIL rst_mid_dout: dout=%h expected 00", dout); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL rst_mid_irq: irq=%b expected 0", irq); end
    rd(2'd2, 8'h00, "rst_mid_ctrl");
    rd(2'd0, 8'hFF, "rst_mid_lo");
    rd(2'd1, 8'hFF, "rst_mid_hi");
    rd(2'd3, 8'h00, "rst_mid_status");
  endtask

  initial begin
    test_reset;
    test_continuous;
    test_oneshot;
    test_tear_free;
    test_collisions;
    test_prescale;
    test_reset_override;
    cycles(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: left=%0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
